alu_mc: RTL and testbench

Parametrised multicycle ALU; successor to the 32-bit single-cycle ALU. Adds a WIDTH parameter, a start/ready handshake, registered outputs, and iterative signed multiply and divide. It sits between the register-file read stage and writeback of the processor datapath. Stall control is driven from `busy`.

---
 rtl/alu_mc_pkg.sv | 19 +
 rtl/alu_mc_iter.sv | 109 ++++++++++
 rtl/alu_mc.sv | 160 ++++++++++++++++
 tb/tb_alu_mc.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_mc_pkg.sv
// Shared opcodes and FSM state encoding for the multicycle ALU.
package alu_mc_pkg;

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SUB = 5'b00001;
    localparam logic [4:0] OP_AND = 5'b00010;
    localparam logic [4:0] OP_OR  = 5'b00011;
    localparam logic [4:0] OP_SLL = 5'b00100;
    localparam logic [4:0] OP_SRA = 5'b00101;
    localparam logic [4:0] OP_MUL = 5'b00110;
    localparam logic [4:0] OP_DIV = 5'b00111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_mc_iter.sv
// Iterative signed multiply (shift-add) and, with ALU_MC_DIV_EN, restoring divide.
// result/overflow are the sign-fixed outcome of the step taken this cycle.
module alu_mc_iter #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             run,
`ifdef ALU_MC_DIV_EN
    input  logic             mode,
`endif
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             last,
    output logic [WIDTH-1:0] result,
    output logic             overflow
);

    logic [2*WIDTH-1:0] acc_q, acc_d, acc_step, mul_next, prod;
    logic [WIDTH-1:0]   addend_q, addend_d, mag_a, mag_b, mul_add;
    logic [WIDTH:0]     mul_sum;
    logic [SHW-1:0]     cnt_q, cnt_d;
    logic               neg_q, neg_d;
`ifdef ALU_MC_DIV_EN
    logic               mode_q, mode_d;
    logic [WIDTH:0]     div_shift, div_diff;
    logic [2*WIDTH-1:0] div_next;
`endif

    always_comb begin
        mag_a    = op_a[WIDTH-1] ? -op_a : op_a;
        mag_b    = op_b[WIDTH-1] ? -op_b : op_b;
        acc_d    = acc_q;
        addend_d = addend_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;

        // Multiply: accumulator low half holds the multiplier, consumed LSB first.
        mul_add  = acc_q[0] ? addend_q : '0;
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_add};
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};
        acc_step = mul_next;
`ifdef ALU_MC_DIV_EN
        mode_d    = mode_q;
        // Divide: high half is the partial remainder, low half dividend -> quotient.
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, addend_q};
        div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        if (mode_q) begin
            acc_step = div_next;
        end
`endif

        prod     = neg_q ? -acc_step : acc_step;
        result   = prod[WIDTH-1:0];
        overflow = !((&prod[2*WIDTH-1:WIDTH-1]) || !(|prod[2*WIDTH-1:WIDTH-1]));
`ifdef ALU_MC_DIV_EN
        if (mode_q) begin
            result   = neg_q ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
            overflow = !neg_q && acc_step[WIDTH-1];
        end
`endif

        if (load) begin
            neg_d    = op_a[WIDTH-1] ^ op_b[WIDTH-1];
            cnt_d    = SHW'(WIDTH - 1);
            acc_d    = {{WIDTH{1'b0}}, mag_b};
            addend_d = mag_a;
`ifdef ALU_MC_DIV_EN
            mode_d = mode;
            if (mode) begin
                acc_d    = {{WIDTH{1'b0}}, mag_a};
                addend_d = mag_b;
            end
`endif
        end else if (run) begin
            acc_d = acc_step;
            if (cnt_q != '0) begin
                cnt_d = cnt_q - SHW'(1);
            end
        end
    end

    assign last = (cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            addend_q <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
`ifdef ALU_MC_DIV_EN
            mode_q   <= 1'b0;
`endif
        end else begin
            acc_q    <= acc_d;
            addend_q <= addend_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
`ifdef ALU_MC_DIV_EN
            mode_q   <= mode_d;
`endif
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multicycle ALU: single-cycle ops, flags and FSM; MUL/DIV via alu_mc_iter.
// Define ALU_MC_DIV_EN to build the divider; otherwise DIV completes with exception set.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             ctrl_start,
    input  logic [4:0]       ctrl_ALUopcode,
    input  logic [SHW-1:0]   ctrl_shiftamt,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_resultRDY,
    output logic             isNotEqual,
    output logic             isLessThan,
    output logic             overflow,
    output logic             exception,
    output logic             busy,
    output state_e           dbg_state
);

    // Handshake: a start is taken on any rising edge where busy=0; the result and
    // flags are valid for exactly the one cycle data_resultRDY is high, then held.
    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d, sum, diff, sc_result, iter_result;
    logic             ne_q, ne_d, lt_q, lt_d, ovf_q, ovf_d, exc_q, exc_d;
    logic             pend_ne_q, pend_ne_d, pend_lt_q, pend_lt_d;
    logic             sub_ovf, add_ovf, cmp_ne, cmp_lt;
    logic             sc_ovf, sc_exc, sc_legal, is_iter, accept;
    logic             iter_last, iter_ovf;

    always_comb begin
        sum     = data_operandA + data_operandB;
        diff    = data_operandA - data_operandB;
        add_ovf = ~(data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1])
                  & (sum[WIDTH-1] ^ data_operandA[WIDTH-1]);
        sub_ovf = (data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1])
                  & (diff[WIDTH-1] ^ data_operandA[WIDTH-1]);
        cmp_ne  = (data_operandA != data_operandB);
        cmp_lt  = diff[WIDTH-1] ^ sub_ovf;

        sc_result = '0;
        sc_ovf    = 1'b0;
        sc_exc    = 1'b0;
        sc_legal  = 1'b1;
        is_iter   = 1'b0;
        case (ctrl_ALUopcode)
            OP_ADD: begin sc_result = sum;  sc_ovf = add_ovf; end
            OP_SUB: begin sc_result = diff; sc_ovf = sub_ovf; end
            OP_AND: sc_result = data_operandA & data_operandB;
            OP_OR:  sc_result = data_operandA | data_operandB;
            OP_SLL: sc_result = data_operandA << ctrl_shiftamt;
            OP_SRA: sc_result = $signed(data_operandA) >>> ctrl_shiftamt;
            OP_MUL: is_iter = 1'b1;
`ifdef ALU_MC_DIV_EN
            OP_DIV: begin
                if (data_operandB == '0) sc_exc = 1'b1;
                else                     is_iter = 1'b1;
            end
`else
            OP_DIV: sc_exc = 1'b1;
`endif
            default: sc_legal = 1'b0;
        endcase

        accept = ctrl_start && (state_q != S_ITER);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) state_d = is_iter ? S_ITER : S_DONE;
                else        state_d = S_IDLE;
            end
            S_ITER:  if (iter_last) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        result_d  = result_q;
        ne_d      = ne_q;
        lt_d      = lt_q;
        ovf_d     = ovf_q;
        exc_d     = exc_q;
        pend_ne_d = pend_ne_q;
        pend_lt_d = pend_lt_q;
        if (accept && !is_iter) begin
            result_d = sc_result;
            ovf_d    = sc_ovf;
            exc_d    = sc_exc;
            ne_d     = cmp_ne & sc_legal;
            lt_d     = cmp_lt & sc_legal;
        end
        // Compare flags come from the operands seen at start, not at completion.
        if (accept && is_iter) begin
            pend_ne_d = cmp_ne;
            pend_lt_d = cmp_lt;
        end
        if (state_q == S_ITER && iter_last) begin
            result_d = iter_result;
            ovf_d    = iter_ovf;
            exc_d    = 1'b0;
            ne_d     = pend_ne_q;
            lt_d     = pend_lt_q;
        end
    end

    alu_mc_iter #(.WIDTH(WIDTH), .SHW(SHW)) u_iter (
        .clk      (clock),
        .rst_n    (resetn),
        .load     (accept && is_iter),
        .run      (state_q == S_ITER),
`ifdef ALU_MC_DIV_EN
        .mode     (ctrl_ALUopcode == OP_DIV),
`endif
        .op_a     (data_operandA),
        .op_b     (data_operandB),
        .last     (iter_last),
        .result   (iter_result),
        .overflow (iter_ovf)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            result_q  <= '0;
            ne_q      <= 1'b0;
            lt_q      <= 1'b0;
            ovf_q     <= 1'b0;
            exc_q     <= 1'b0;
            pend_ne_q <= 1'b0;
            pend_lt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            ne_q      <= ne_d;
            lt_q      <= lt_d;
            ovf_q     <= ovf_d;
            exc_q     <= exc_d;
            pend_ne_q <= pend_ne_d;
            pend_lt_q <= pend_lt_d;
        end
    end

    assign data_result    = result_q;
    assign data_resultRDY = (state_q == S_DONE);
    assign busy           = (state_q == S_ITER);
    assign isNotEqual     = ne_q;
    assign isLessThan     = lt_q;
    assign overflow       = ovf_q;
    assign exception      = exc_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (WIDTH=32) against a plain-arithmetic reference model.
module tb_alu_mc;
    import alu_mc_pkg::*;

    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    logic        clock, resetn, ctrl_start;
    logic [4:0]  ctrl_ALUopcode, ctrl_shiftamt;
    logic [31:0] data_operandA, data_operandB, data_result;
    logic        data_resultRDY, isNotEqual, isLessThan, overflow, exception, busy;
    state_e      dbg_state;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [31:0] res;
        logic        ne, lt, ovf, exc;
        int          lat;
    } exp_t;

    alu_mc dut (
        .clock(clock), .resetn(resetn), .ctrl_start(ctrl_start),
        .ctrl_ALUopcode(ctrl_ALUopcode), .ctrl_shiftamt(ctrl_shiftamt),
        .data_operandA(data_operandA), .data_operandB(data_operandB),
        .data_result(data_result), .data_resultRDY(data_resultRDY),
        .isNotEqual(isNotEqual), .isLessThan(isLessThan), .overflow(overflow),
        .exception(exception), .busy(busy), .dbg_state(dbg_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: signed integer arithmetic on 64-bit values.
    function automatic exp_t model(input logic [4:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [4:0] sh);
        exp_t e;
        longint sa, sb, r;
        sa = $signed(a);
        sb = $signed(b);
        e.res = 32'h0; e.ne = (a != b); e.lt = (sa < sb);
        e.ovf = 1'b0; e.exc = 1'b0; e.lat = 1;
        case (op)
            5'd0: begin r = sa + sb; e.res = r[31:0]; e.ovf = (r > MAXV) || (r < MINV); end
            5'd1: begin r = sa - sb; e.res = r[31:0]; e.ovf = (r > MAXV) || (r < MINV); end
            5'd2: e.res = a & b;
            5'd3: e.res = a | b;
            5'd4: e.res = a << sh;
            5'd5: e.res = $signed(a) >>> sh;
            5'd6: begin
                r = sa * sb; e.res = r[31:0];
                e.ovf = (r > MAXV) || (r < MINV); e.lat = 33;
            end
            5'd7: begin
`ifdef ALU_MC_DIV_EN
                if (b == 32'h0) begin
                    e.exc = 1'b1;
                end else if (sa == MINV && sb == -64'sd1) begin
                    e.res = a; e.ovf = 1'b1; e.lat = 33;
                end else begin
                    r = sa / sb; e.res = r[31:0]; e.lat = 33;
                end
`else
                e.exc = 1'b1;
`endif
            end
            default: begin e.ne = 1'b0; e.lt = 1'b0; end
        endcase
        return e;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h7FFF_FFFF;
            4: return $urandom_range(0, 20) - 32'd10;
            default: return $urandom;
        endcase
    endfunction

    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] sh, input string name);
        exp_t e;
        int cyc, busy_cyc;
        e = model(op, a, b, sh);
        @(negedge clock);
        ctrl_ALUopcode = op; data_operandA = a; data_operandB = b;
        ctrl_shiftamt = sh; ctrl_start = 1'b1;
        @(negedge clock);
        ctrl_start = 1'b0;
        ctrl_ALUopcode = 5'($urandom); ctrl_shiftamt = 5'($urandom);
        data_operandA = $urandom; data_operandB = $urandom;
        cyc = 1; busy_cyc = 0;
        while (data_resultRDY !== 1'b1 && cyc < 100) begin
            if (busy === 1'b1) busy_cyc++;
            @(negedge clock);
            cyc++;
        end
        checks++;
        if (data_resultRDY !== 1'b1) begin
            errors++;
            $display("FAIL %s timeout: no rdy after %0d cycles", name, cyc);
            return;
        end
        checks++;
        if (cyc !== e.lat) begin errors++; $display("FAIL %s latency: got %0d exp %0d", name, cyc, e.lat); end
        checks++;
        if (busy_cyc !== e.lat - 1) begin errors++; $display("FAIL %s busy cycles: got %0d exp %0d", name, busy_cyc, e.lat - 1); end
        checks++;
        if (data_result !== e.res) begin errors++; $display("FAIL %s result: got %h exp %h", name, data_result, e.res); end
        checks++;
        if ({isNotEqual, isLessThan, overflow, exception} !== {e.ne, e.lt, e.ovf, e.exc}) begin
            errors++;
            $display("FAIL %s flags ne/lt/ovf/exc: got %b%b%b%b exp %b%b%b%b", name,
                     isNotEqual, isLessThan, overflow, exception, e.ne, e.lt, e.ovf, e.exc);
        end
        @(negedge clock);
        checks++;
        if (data_resultRDY !== 1'b0) begin errors++; $display("FAIL %s rdy pulse: still high, got %b exp 0", name, data_resultRDY); end
    endtask

    task automatic test_reset();
        resetn = 1'b0; ctrl_start = 1'b0; ctrl_ALUopcode = 5'd0; ctrl_shiftamt = 5'd0;
        data_operandA = 32'h0; data_operandB = 32'h0;
        repeat (3) @(negedge clock);
        checks++;
        if ({data_result, data_resultRDY, isNotEqual, isLessThan, overflow, exception, busy} !== 38'h0
            || dbg_state !== S_IDLE) begin
            errors++;
            $display("FAIL reset outputs: got res=%h rdy=%b busy=%b state=%0d exp all 0 / idle",
                     data_result, data_resultRDY, busy, dbg_state);
        end
        resetn = 1'b1;
    endtask

    task automatic test_directed();
        run_op(5'd0, 32'h7FFF_FFFF, 32'h1, 5'd0, "add_ovf");
        run_op(5'd1, 32'h8000_0000, 32'h1, 5'd0, "sub_ovf");
        run_op(5'd5, 32'h8000_0000, 32'h0, 5'd4, "sra4");
        run_op(5'd4, 32'h1, 32'h0, 5'd31, "sll31");
        run_op(5'd4, 32'hA5A5_1234, 32'h0, 5'd0, "sll0");
        run_op(5'd5, 32'hA5A5_1234, 32'h0, 5'd0, "sra0");
        run_op(5'd2, 32'hF0F0_FF00, 32'h0FF0_F0F0, 5'd0, "and");
        run_op(5'd3, 32'hF0F0_0000, 32'h0000_0F0F, 5'd0, "or");
        run_op(5'd6, -32'sd7, 32'd6, 5'd0, "mul_neg");
        run_op(5'd6, 32'h1_0000, 32'h1_0000, 5'd0, "mul_ovf");
        run_op(5'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, "mul_min_m1");
        run_op(5'd7, -32'sd7, 32'd2, 5'd0, "div_neg");
        run_op(5'd7, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, "div_ovf");
        run_op(5'd7, 32'd5, 32'd0, 5'd0, "div_zero");
        run_op(5'd7, 32'd100, 32'd5, 5'd0, "div_100_5");
        run_op(5'd31, 32'd9, 32'd4, 5'd3, "illegal_op");
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            run_op(5'($urandom_range(0, 9)), pick_operand(), pick_operand(),
                   5'($urandom), $sformatf("rand%0d", i));
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [31:0] a, b, want;
        logic [4:0] op, sh;
        @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin
                want = exp_q.pop_front();
                checks++;
                if (data_resultRDY !== 1'b1 || data_result !== want) begin
                    errors++;
                    $display("FAIL b2b%0d: got rdy=%b res=%h exp rdy=1 res=%h", i - 1, data_resultRDY, data_result, want);
                end
            end
            if (i == 0) begin op = 5'd5; a = 32'h8000_0000; b = 32'h0; sh = 5'd4; end
            else if (i == 1) begin op = 5'd4; a = 32'h1; b = 32'h0; sh = 5'd31; end
            else begin op = 5'($urandom_range(0, 5)); a = pick_operand(); b = pick_operand(); sh = 5'($urandom); end
            e = model(op, a, b, sh);
            exp_q.push_back(e.res);
            ctrl_ALUopcode = op; data_operandA = a; data_operandB = b; ctrl_shiftamt = sh; ctrl_start = 1'b1;
            @(negedge clock);
        end
        ctrl_start = 1'b0;
        want = exp_q.pop_front();
        checks++;
        if (data_resultRDY !== 1'b1 || data_result !== want) begin
            errors++;
            $display("FAIL b2b7: got rdy=%b res=%h exp rdy=1 res=%h", data_resultRDY, data_result, want);
        end
        @(negedge clock);
    endtask

    task automatic test_start_during_iter();
        exp_t e;
        int rdy_cnt, rdy_at;
        logic [31:0] got;
        e = model(5'd6, -32'sd7, 32'd6, 5'd0);
        @(negedge clock);
        ctrl_ALUopcode = 5'd6; data_operandA = -32'sd7; data_operandB = 32'd6; ctrl_start = 1'b1;
        @(negedge clock);
        ctrl_start = 1'b0; data_operandA = 32'd5; data_operandB = 32'd3;
        rdy_cnt = 0; rdy_at = 0; got = 32'h0;
        for (int c = 1; c <= 60; c++) begin
            if (data_resultRDY === 1'b1) begin
                rdy_cnt++;
                if (rdy_at == 0) begin rdy_at = c; got = data_result; end
            end
            if (c == 10) begin ctrl_ALUopcode = 5'd0; ctrl_start = 1'b1; end
            else ctrl_start = 1'b0;
            @(negedge clock);
        end
        checks++;
        if (rdy_cnt !== 1 || rdy_at !== 33) begin
            errors++;
            $display("FAIL ignore_start rdy: got count=%0d at=%0d exp count=1 at=33", rdy_cnt, rdy_at);
        end
        checks++;
        if (got !== e.res) begin errors++; $display("FAIL ignore_start result: got %h exp %h", got, e.res); end
    endtask

    task automatic test_reset_mid_iter();
        int rdy_cnt;
        run_op(5'd0, 32'd1, 32'd2, 5'd0, "pre_reset_add");
        @(negedge clock);
        ctrl_ALUopcode = 5'd6; data_operandA = 32'd1234; data_operandB = 32'd77; ctrl_start = 1'b1;
        @(negedge clock);
        ctrl_start = 1'b0;
        repeat (5) @(negedge clock);
        #2 resetn = 1'b0;
        #1;
        checks++;
        if ({data_result, data_resultRDY, isNotEqual, isLessThan, overflow, exception, busy} !== 38'h0) begin
            errors++;
            $display("FAIL async_reset: got res=%h rdy=%b busy=%b exp all 0", data_result, data_resultRDY, busy);
        end
        @(negedge clock);
        @(negedge clock);
        resetn = 1'b1;
        rdy_cnt = 0;
        repeat (40) begin
            @(negedge clock);
            if (data_resultRDY === 1'b1) rdy_cnt++;
        end
        checks++;
        if (rdy_cnt !== 0) begin errors++; $display("FAIL reset_no_rdy: got %0d pulses exp 0", rdy_cnt); end
        run_op(5'd0, 32'd5, 32'd3, 5'd0, "post_reset_add");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_start_during_iter();
        test_reset_mid_iter();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
